// File: rtl/reg_bank_pkg.sv
// Shared types for the register-bank arbiter: FSM state encoding and op select values.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    gnt_idx,
  output logic             valid
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!valid && req[idx]) begin
        valid        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write/clear arbiter for a shared register bank, with a clear-all sweep
// that takes priority over requests. Every output is driven straight from a flop.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_REG = 8,
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_all,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_clr,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic [N_REG-1:0]       reg_w,
  output logic [N_REG-1:0]       reg_cl,
  output logic [WIDTH-1:0]       reg_din,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AW:0] N_REG_W = (AW+1)'(N_REG);

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic [N_REG-1:0]   reg_w_q, reg_w_d;
  logic [N_REG-1:0]   reg_cl_q, reg_cl_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_valid;

  logic               sel_op;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_data;
  logic [N_REG-1:0]   hit;
  logic               in_range;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .valid   (gnt_valid)
  );

  // Winner's op/addr/data, selected by the one-hot grant.
  always_comb begin
    sel_op   = OP_WRITE;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_op   = req_clr[i];
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int r = 0; r < N_REG; r++) begin
      hit[r] = (sel_addr == AW'(r));
    end
    in_range = ({1'b0, sel_addr} < N_REG_W);
  end

  // The grant is decoded while still in IDLE so the strobes are registered on the
  // same edge that enters ISSUE; the output flops hold the latched transaction.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    err_d    = 1'b0;
    reg_w_d  = '0;
    reg_cl_d = '0;
    din_d    = '0;
    case (state_q)
      IDLE: begin
        if (clr_all) begin
          state_d  = CLEAR;
          reg_cl_d = '1;
        end else if (gnt_valid) begin
          state_d = ISSUE;
          ptr_d   = gnt_idx;
          ack_d   = gnt;
          if (in_range) begin
            if (sel_op == OP_WRITE) begin
              reg_w_d = hit;
              din_d   = sel_data;
            end else begin
              reg_cl_d = hit;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE:   state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= PW'(N_REQ - 1);
      ack_q    <= '0;
      err_q    <= 1'b0;
      reg_w_q  <= '0;
      reg_cl_q <= '0;
      din_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      reg_w_q  <= reg_w_d;
      reg_cl_q <= reg_cl_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign reg_w   = reg_w_q;
  assign reg_cl  = reg_cl_q;
  assign reg_din = din_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: write, round-robin order, clear-all priority,
// clear op, out-of-range address and asynchronous reset during a transaction.
module tb_reg_bank_arbiter;

  localparam int N_REQ = 4;
  localparam int N_REG = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   clr_all;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       req_clr;
  logic [N_REQ*AW-1:0]    req_addr;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic [N_REG-1:0]       reg_w;
  logic [N_REG-1:0]       reg_cl;
  logic [WIDTH-1:0]       reg_din;
  logic                   busy;

  int n_cmp;
  int n_err;

  reg_bank_arbiter #(
    .N_REQ (N_REQ),
    .N_REG (N_REG),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_all  (clr_all),
    .req      (req),
    .req_clr  (req_clr),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .reg_w    (reg_w),
    .reg_cl   (reg_cl),
    .reg_din  (reg_din),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    clr_all  = 1'b0;
    req      = '0;
    req_clr  = '0;
    req_addr = '0;
    req_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic clr, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] data);
    req[i]                   = 1'b1;
    req_clr[i]               = clr;
    req_addr[i*AW +: AW]     = addr;
    req_data[i*WIDTH +: WIDTH] = data;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"},  32'(ack),     32'h0);
    check({tag, "_w"},    32'(reg_w),   32'h0);
    check({tag, "_cl"},   32'(reg_cl),  32'h0);
    check({tag, "_din"},  32'(reg_din), 32'h0);
    check({tag, "_err"},  32'(err),     32'h0);
    check({tag, "_busy"}, 32'(busy),    32'h0);
  endtask

  // Expected grant order for the two round-robin phases.
  int exp_order_a [4] = '{0, 1, 2, 3};
  int exp_order_b [4] = '{1, 3, 1, 3};

  initial begin
    n_cmp = 0;
    n_err = 0;

    do_reset();
    check_idle("reset");

    // single write: requester 2, addr 5, data 0xA5
    set_req(2, 1'b0, 4'd5, 8'hA5);
    tick();
    check("wr_w",    32'(reg_w),   32'h20);
    check("wr_din",  32'(reg_din), 32'hA5);
    check("wr_ack",  32'(ack),     32'h4);
    check("wr_busy", 32'(busy),    32'h1);
    check("wr_cl",   32'(reg_cl),  32'h0);
    req = '0;
    tick();
    check_idle("wr_after");

    // round-robin with all four active, each dropped after its ack
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, AW'(i + 1), WIDTH'(8'h10 + i));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_a_ack", 32'(ack),     32'(1 << exp_order_a[k]));
      check("rr_a_w",   32'(reg_w),   32'(1 << (exp_order_a[k] + 1)));
      check("rr_a_din", 32'(reg_din), 32'(8'h10 + exp_order_a[k]));
      req[exp_order_a[k]] = 1'b0;
      tick();
      check("rr_a_gap", 32'(ack), 32'h0);
    end

    // requesters 1 and 3 held continuously
    set_req(1, 1'b0, 4'd2, 8'h21);
    set_req(3, 1'b0, 4'd4, 8'h23);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_b_ack", 32'(ack), 32'(1 << exp_order_b[k]));
      if (k == 3) req = '0;
      tick();
      check("rr_b_gap", 32'(ack), 32'h0);
    end

    // clear-all together with a request: sweep first, then requester 0
    clr_all = 1'b1;
    set_req(0, 1'b0, 4'd2, 8'h5A);
    tick();
    check("ca_cl",   32'(reg_cl), 32'hFF);
    check("ca_ack",  32'(ack),    32'h0);
    check("ca_w",    32'(reg_w),  32'h0);
    check("ca_busy", 32'(busy),   32'h1);
    clr_all = 1'b0;
    tick();
    check("ca_gap_ack", 32'(ack),    32'h0);
    check("ca_gap_cl",  32'(reg_cl), 32'h0);
    tick();
    check("ca_next_ack", 32'(ack),     32'h1);
    check("ca_next_w",   32'(reg_w),   32'h04);
    check("ca_next_din", 32'(reg_din), 32'h5A);
    req = '0;
    tick();

    // clear op: requester 1, addr 3
    set_req(1, 1'b1, 4'd3, 8'hFF);
    tick();
    check("cop_cl",  32'(reg_cl),  32'h08);
    check("cop_w",   32'(reg_w),   32'h0);
    check("cop_din", 32'(reg_din), 32'h0);
    check("cop_ack", 32'(ack),     32'h2);
    check("cop_err", 32'(err),     32'h0);
    req = '0;
    tick();

    // out-of-range address: requester 0, addr 9
    set_req(0, 1'b0, 4'd9, 8'h77);
    tick();
    check("bad_ack", 32'(ack),     32'h1);
    check("bad_err", 32'(err),     32'h1);
    check("bad_w",   32'(reg_w),   32'h0);
    check("bad_cl",  32'(reg_cl),  32'h0);
    check("bad_din", 32'(reg_din), 32'h0);
    req = '0;
    tick();
    check("bad_err_drop", 32'(err), 32'h0);

    // clr_all rising during ISSUE: transaction finishes, then the sweep
    set_req(2, 1'b0, 4'd0, 8'h33);
    tick();
    check("ci_ack", 32'(ack), 32'h4);
    clr_all = 1'b1;
    req     = '0;
    tick();
    check("ci_gap_cl", 32'(reg_cl), 32'h0);
    tick();
    check("ci_cl", 32'(reg_cl), 32'hFF);
    clr_all = 1'b0;
    tick();

    // asynchronous reset while a write strobe is high
    do_reset();
    set_req(3, 1'b0, 4'd6, 8'hC3);
    tick();
    check("ar_w_pre", 32'(reg_w), 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_w",    32'(reg_w),   32'h0);
    check("ar_ack",  32'(ack),     32'h0);
    check("ar_din",  32'(reg_din), 32'h0);
    check("ar_busy", 32'(busy),    32'h0);
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, AW'(i), WIDTH'(i));
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_first_ack", 32'(ack),   32'h1);
    check("ar_first_w",   32'(reg_w), 32'h1);
    req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
